// File: rtl/spi_mstr_ctrl_if.sv
// Signal bundle between the SPI master transaction controller, its SCLK
// divider, the serial lines and the command source.
interface spi_mstr_ctrl_if #(
    parameter int WIDTH = 16
);
    // wrt/done handshake: wrt is a one-clk request honoured only while the
    // controller is idle (ld_SCLK = 1); a wrt seen while busy is dropped, not
    // queued. done rises when the word is complete and stays high, with
    // rd_data valid, until the next accepted wrt.
    logic             wrt;
    logic [WIDTH-1:0] cmd;
    logic             done;
    logic [WIDTH-1:0] rd_data;

    // Divider strobes in, divider hold/reload out.
    logic             shft;
    logic             full;
    logic             ld_SCLK;

    // Serial side.
    logic             SS_n;
    logic             MOSI;
    logic             MISO;

    // FSM state for checkers: 0 = IDLE, 1 = SHIFTING.
    logic             dbg_state;

    modport master (
        input  wrt, cmd, shft, full, MISO,
        output done, rd_data, ld_SCLK, SS_n, MOSI, dbg_state
    );

    modport slave (
        output wrt, cmd, shft, full, MISO,
        input  done, rd_data, ld_SCLK, SS_n, MOSI, dbg_state
    );
endinterface

// File: rtl/spi_mstr_ctrl.sv
// SPI master transaction controller: one wrt pulse gives one full-duplex,
// MSB-first, mode-0 transfer of WIDTH bits. Define SPI_XFER_CNT_EN to add xfer_cnt.
module spi_mstr_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SPI_XFER_CNT_EN
    output logic [15:0] xfer_cnt,
`endif
    spi_mstr_ctrl_if.master bus
);
    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE     = 1'b0,
        SHIFTING = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             ss_n_q;
    logic             done_q;
    logic             xfer_end;

    // Only the full strobe that follows the last shft closes the frame; the
    // front-porch full and the mid-word ones see bit_cnt < WIDTH.
    assign xfer_end = (state == SHIFTING) && bus.full && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            ss_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wrt) begin
                        shreg   <= bus.cmd;
                        bit_cnt <= '0;
                        ss_n_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state   <= SHIFTING;
                    end
                end
                SHIFTING: begin
                    // MISO is taken raw: shft lands one clk after the SCLK rise,
                    // well inside the window where the slave holds it stable.
                    if (bus.shft) begin
                        shreg   <= {shreg[WIDTH-2:0], bus.MISO};
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                    if (xfer_end) begin
                        ss_n_q <= 1'b1;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ld_SCLK   = (state == IDLE);
    assign bus.SS_n      = ss_n_q;
    assign bus.done      = done_q;
    assign bus.MOSI      = shreg[WIDTH-1];
    assign bus.rd_data   = shreg;
    assign bus.dbg_state = (state == SHIFTING);

`ifdef SPI_XFER_CNT_EN
    logic [15:0] cnt_q;

    // Counts on the edge done rises; a reset-aborted frame never reaches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (xfer_end) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_spi_mstr_ctrl.sv
// Bench for spi_mstr_ctrl: SCLK divider model (SCLK high 9 clks after ld_SCLK
// drops, 32-clk period), mode-0 slave model, scoreboard on rd_data.
module tb_spi_mstr_ctrl;
    localparam int WIDTH    = 16;
    localparam int XFER_CYC = 32 * WIDTH + 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_mstr_ctrl_if #(.WIDTH(WIDTH)) bus ();

`ifdef SPI_XFER_CNT_EN
    logic [15:0] xfer_cnt;
    spi_mstr_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .xfer_cnt(xfer_cnt), .bus(bus));
`else
    spi_mstr_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_slave_q[$];

    // ---------------- divider model ----------------
    logic [4:0] div_cnt = 5'd24;
    logic       sclk;
    always @(posedge clk) div_cnt <= bus.ld_SCLK ? 5'd24 : div_cnt + 5'd1;
    assign sclk     = bus.ld_SCLK | div_cnt[4];
    assign bus.shft = (div_cnt == 5'd17);
    assign bus.full = (div_cnt == 5'd31);

    // ---------------- slave model ----------------
    logic             loop_en = 1'b1;
    logic [WIDTH-1:0] slave_word = '0;
    logic [WIDTH-1:0] slave_tx = '0;
    logic [WIDTH-1:0] slave_rx = '0;
    int               rise_cnt = 0;
    logic             sclk_q = 1'b1;

    always @(posedge clk) begin
        sclk_q <= sclk;
        if (bus.SS_n) begin
            slave_tx <= slave_word;
            slave_rx <= '0;
            rise_cnt <= 0;
        end else begin
            if (sclk && !sclk_q) begin
                slave_rx <= {slave_rx[WIDTH-2:0], bus.MOSI};
                rise_cnt <= rise_cnt + 1;
            end
            if (!sclk && sclk_q && rise_cnt > 0) slave_tx <= {slave_tx[WIDTH-2:0], 1'b0};
        end
    end
    assign bus.MISO = loop_en ? bus.MOSI : slave_tx[WIDTH-1];

    // ---------------- driver tasks ----------------
    // Ends at the negedge after the accepting edge, i.e. sampling point of cycle 1.
    task automatic start_wrt(input logic [WIDTH-1:0] c, input logic hold);
        @(negedge clk);
        bus.cmd = c;
        bus.wrt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.wrt = 1'b0;
    endtask

    // Returns the cycle in which done is first seen (bounded) and how many
    // cycles before it had SS_n low. Optionally pulses wrt at cycle pulse_at.
    task automatic wait_done(input int pulse_at, input logic [WIDTH-1:0] pulse_cmd,
                             output int n, output int ss_low);
        n = 1;
        ss_low = 0;
        while (bus.done !== 1'b1 && n <= XFER_CYC + 200) begin
            if (bus.SS_n === 1'b0) ss_low++;
            @(negedge clk);
            n++;
            if (n == pulse_at) begin
                bus.cmd = pulse_cmd;
                bus.wrt = 1'b1;
            end else if (n == pulse_at + 1) begin
                bus.wrt = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.wrt = 1'b1;
        bus.cmd = 16'hFFFF;
        loop_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.SS_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n got=%b exp=1", bus.SS_n); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.ld_SCLK !== 1'b1) begin failures++; $display("FAIL reset_ld_sclk got=%b exp=1", bus.ld_SCLK); end
        checks++; if (bus.MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", bus.MOSI); end
        checks++; if (bus.rd_data !== 16'h0000) begin failures++; $display("FAIL reset_rd_data got=%h exp=0000", bus.rd_data); end
        checks++; if (bus.dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", bus.dbg_state); end
        bus.wrt = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.SS_n !== 1'b1) begin failures++; $display("FAIL post_reset_idle got=%b exp=1", bus.SS_n); end
    endtask

    task automatic test_loopback();
        int n, ss_low;
        logic [WIDTH-1:0] exp;
        loop_en = 1'b1;
        exp_q.push_back(16'hA5C3);
        start_wrt(16'hA5C3, 1'b0);
        checks++; if (bus.SS_n !== 1'b0) begin failures++; $display("FAIL lb_ss_n_c1 got=%b exp=0", bus.SS_n); end
        checks++; if (bus.ld_SCLK !== 1'b0) begin failures++; $display("FAIL lb_ld_sclk_c1 got=%b exp=0", bus.ld_SCLK); end
        checks++; if (bus.MOSI !== 1'b1) begin failures++; $display("FAIL lb_mosi_first_bit got=%b exp=1", bus.MOSI); end
        wait_done(-1, '0, n, ss_low);
        checks++; if (n != XFER_CYC) begin failures++; $display("FAIL lb_done_cycle got=%0d exp=%0d", n, XFER_CYC); end
        checks++; if (ss_low != XFER_CYC - 1) begin failures++; $display("FAIL lb_ss_low_cycles got=%0d exp=%0d", ss_low, XFER_CYC - 1); end
        checks++; if (rise_cnt != WIDTH) begin failures++; $display("FAIL lb_sclk_rises got=%0d exp=%0d", rise_cnt, WIDTH); end
        checks++; if (bus.SS_n !== 1'b1) begin failures++; $display("FAIL lb_ss_n_end got=%b exp=1", bus.SS_n); end
        if (exp_q.size() == 0) begin failures++; $display("FAIL lb_scoreboard_empty got=0 exp=1"); end
        else begin
            exp = exp_q.pop_front();
            checks++; if (bus.rd_data !== exp) begin failures++; $display("FAIL lb_rd_data got=%h exp=%h", bus.rd_data, exp); end
        end
    endtask

    task automatic test_slave_data();
        int n, ss_low;
        logic [WIDTH-1:0] exp;
        loop_en = 1'b0;
        slave_word = 16'h3C5A;
        exp_q.push_back(16'h3C5A);
        exp_slave_q.push_back(16'hFFFF);
        start_wrt(16'hFFFF, 1'b0);
        wait_done(-1, '0, n, ss_low);
        checks++; if (n != XFER_CYC) begin failures++; $display("FAIL sd_done_cycle got=%0d exp=%0d", n, XFER_CYC); end
        if (exp_q.size() == 0 || exp_slave_q.size() == 0) begin failures++; $display("FAIL sd_scoreboard_empty got=0 exp=1"); end
        else begin
            exp = exp_q.pop_front();
            checks++; if (bus.rd_data !== exp) begin failures++; $display("FAIL sd_rd_data got=%h exp=%h", bus.rd_data, exp); end
            exp = exp_slave_q.pop_front();
            checks++; if (slave_rx !== exp) begin failures++; $display("FAIL sd_slave_rx got=%h exp=%h", slave_rx, exp); end
        end
        repeat (5) @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL sd_done_sticky got=%b exp=1", bus.done); end
        checks++; if (bus.rd_data !== 16'h3C5A) begin failures++; $display("FAIL sd_rd_data_hold got=%h exp=3c5a", bus.rd_data); end
        loop_en = 1'b1;
    endtask

    task automatic test_wrt_ignored();
        int n, ss_low;
        logic [WIDTH-1:0] exp;
        exp_q.push_back(16'h1234);
        start_wrt(16'h1234, 1'b0);
        wait_done(100, 16'hBEEF, n, ss_low);
        checks++; if (n != XFER_CYC) begin failures++; $display("FAIL ign_done_cycle got=%0d exp=%0d", n, XFER_CYC); end
        if (exp_q.size() == 0) begin failures++; $display("FAIL ign_scoreboard_empty got=0 exp=1"); end
        else begin
            exp = exp_q.pop_front();
            checks++; if (bus.rd_data !== exp) begin failures++; $display("FAIL ign_rd_data got=%h exp=%h", bus.rd_data, exp); end
        end
        repeat (3) @(negedge clk);
        checks++; if (bus.SS_n !== 1'b1) begin failures++; $display("FAIL ign_not_queued got=%b exp=1", bus.SS_n); end
    endtask

    task automatic test_reset_mid();
        int n, ss_low;
        logic [WIDTH-1:0] exp;
        start_wrt(16'h0F0F, 1'b0);
        repeat (299) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.SS_n !== 1'b1) begin failures++; $display("FAIL rm_ss_n got=%b exp=1", bus.SS_n); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rm_done got=%b exp=0", bus.done); end
        checks++; if (bus.ld_SCLK !== 1'b1) begin failures++; $display("FAIL rm_ld_sclk got=%b exp=1", bus.ld_SCLK); end
        checks++; if (bus.rd_data !== 16'h0000) begin failures++; $display("FAIL rm_rd_data got=%h exp=0000", bus.rd_data); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.SS_n !== 1'b1) begin failures++; $display("FAIL rm_not_resumed got=%b exp=1", bus.SS_n); end
        exp_q.push_back(16'h5AA5);
        start_wrt(16'h5AA5, 1'b0);
        wait_done(-1, '0, n, ss_low);
        checks++; if (n != XFER_CYC) begin failures++; $display("FAIL rm_done_cycle got=%0d exp=%0d", n, XFER_CYC); end
        checks++; if (rise_cnt != WIDTH) begin failures++; $display("FAIL rm_sclk_rises got=%0d exp=%0d", rise_cnt, WIDTH); end
        if (exp_q.size() == 0) begin failures++; $display("FAIL rm_scoreboard_empty got=0 exp=1"); end
        else begin
            exp = exp_q.pop_front();
            checks++; if (bus.rd_data !== exp) begin failures++; $display("FAIL rm_rd_data got=%h exp=%h", bus.rd_data, exp); end
        end
    endtask

    task automatic test_back_to_back();
        int n, ss_low;
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] b2b_cmd[3];
        b2b_cmd[0] = 16'h8001;
        b2b_cmd[1] = 16'h7FFE;
        b2b_cmd[2] = 16'hC33C;
        for (int i = 0; i < 3; i++) exp_q.push_back(b2b_cmd[i]);
        start_wrt(b2b_cmd[0], 1'b1);
        for (int t = 0; t < 3; t++) begin
            wait_done(-1, '0, n, ss_low);
            checks++; if (n != XFER_CYC) begin failures++; $display("FAIL b2b_done_cycle t=%0d got=%0d exp=%0d", t, n, XFER_CYC); end
            checks++; if (ss_low != XFER_CYC - 1) begin failures++; $display("FAIL b2b_ss_low t=%0d got=%0d exp=%0d", t, ss_low, XFER_CYC - 1); end
            if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_scoreboard_empty got=0 exp=1"); end
            else begin
                exp = exp_q.pop_front();
                checks++; if (bus.rd_data !== exp) begin failures++; $display("FAIL b2b_rd_data t=%0d got=%h exp=%h", t, bus.rd_data, exp); end
            end
            if (t < 2) begin
                bus.cmd = b2b_cmd[t+1];
                @(negedge clk);
                checks++; if (bus.SS_n !== 1'b0) begin failures++; $display("FAIL b2b_ss_gap t=%0d got=%b exp=0", t, bus.SS_n); end
                checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_done_clear t=%0d got=%b exp=0", t, bus.done); end
            end else begin
                bus.wrt = 1'b0;
                @(negedge clk);
                checks++; if (bus.SS_n !== 1'b1) begin failures++; $display("FAIL b2b_stop got=%b exp=1", bus.SS_n); end
            end
        end
    endtask

`ifdef SPI_XFER_CNT_EN
    task automatic test_xfer_cnt();
        int n, ss_low;
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL xc_reset got=%h exp=0000", xfer_cnt); end
        for (int t = 0; t < 4; t++) begin
            if (t == 3) begin
                force dut.cnt_q = 16'hFFFF;
                @(negedge clk);
                release dut.cnt_q;
            end
            exp_q.push_back(16'h0101 * (t + 1));
            start_wrt(16'h0101 * (t + 1), 1'b0);
            wait_done(-1, '0, n, ss_low);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                checks++; if (bus.rd_data !== exp) begin failures++; $display("FAIL xc_rd_data got=%h exp=%h", bus.rd_data, exp); end
            end
            if (t == 2) begin
                checks++; if (xfer_cnt !== 16'd3) begin failures++; $display("FAIL xc_three got=%h exp=0003", xfer_cnt); end
            end
        end
        checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL xc_wrap got=%h exp=0000", xfer_cnt); end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_loopback();
        test_slave_data();
        test_wrt_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef SPI_XFER_CNT_EN
        test_xfer_cnt();
`endif
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_mstr_ctrl.md
Name: spi_mstr_ctrl

Overview:
- Transaction controller for the SPI master. It sits directly downstream of the SCLK divider: it consumes `SCLK`, `shft` and `full`, and drives `ld_SCLK` back to the divider.
- It owns `SS_n`, the `MOSI`/`MISO` shift register and the `wrt`/`done` handshake toward the command source, for example the codec or ADC config FSM.
- One `wrt` pulse causes one full-duplex transfer of `WIDTH` bits, MSB first, SPI mode 0.

Parameters:
- `WIDTH`, 16, bits per transaction; range 2 to 32. Sets `bit_cnt` width to clog2(`WIDTH`+1).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `wrt`  in  1  start pulse; sampled only in `IDLE`
- `cmd`  in  `WIDTH`  data to transmit; captured on the `wrt` edge
- `MISO`  in  1  serial data from slave
- `shft`  in  1  divider strobe, 1-clk pulse one clk after each SCLK rise
- `full`  in  1  divider strobe, 1-clk pulse in the last clk of each SCLK period
- `ld_SCLK`  out  1  holds or reloads the divider (`SCLK` parked high)
- `SS_n`  out  1  slave select, active low, registered
- `MOSI`  out  1  equals `shreg[WIDTH-1]`
- `done`  out  1  sticky completion flag, registered
- `rd_data`  out  `WIDTH`  equals `shreg`; valid while `done` = 1

Behaviour:
- Reset state (async on `rst`=1, including mid-transaction):
  - state = `IDLE`, `SS_n` = 1, `done` = 0, `shreg` = 0, `bit_cnt` = 0, so `ld_SCLK` = 1 and `MOSI` = 0.
  - A transfer aborted by reset is not resumed.
- States: `IDLE` and `SHIFTING`. `ld_SCLK` is combinational: 1 iff state = `IDLE`.
- `IDLE`, `wrt`=1 at a clk edge (cycle 0):
  - `shreg` <= `cmd`, `bit_cnt` <= 0, `SS_n` <= 0, `done` <= 0, state <= `SHIFTING`.
  - `ld_SCLK` drops in cycle 0; the divider free-runs from its preload.
- `SHIFTING`, `shft`=1:
  - `shreg` <= {`shreg[WIDTH-2:0]`, `MISO`}; `bit_cnt` <= `bit_cnt`+1.
  - `MISO` is sampled raw at that edge. This is 1 clk after SCLK rise, while the slave holds `MISO` stable.
- `SHIFTING`, `full`=1 and `bit_cnt` = `WIDTH`: state <= `IDLE`, `SS_n` <= 1, `done` <= 1.
- `full` with `bit_cnt` < `WIDTH` is ignored. This includes the front-porch `full` in cycle 8, before any `shft`.
- Timing with the divider preload (SCLK high 9 clks after `ld_SCLK` drops):
  - first SCLK fall in cycle 9;
  - shft k (k = 1..`WIDTH`) in cycle 26 + 32(k-1);
  - final qualifying `full` in cycle 32·`WIDTH`+8;
  - `SS_n` = 1 and `done` = 1 from cycle 32·`WIDTH`+9 (= 521 for `WIDTH`=16).
- `MOSI` changes only at `shft` edges (SCLK high), so it is stable at every SCLK rise. The first bit is valid from cycle 1.
- `wrt` while in `SHIFTING`: ignored. No queueing, and `cmd` is not re-captured.
- `wrt` in the same cycle the FSM returns to `IDLE`: ignored, because the FSM is still in `SHIFTING` that cycle. `wrt` is accepted from the next cycle.
- `done` stays high until the next accepted `wrt` or reset. `rd_data` holds its value until then.
- Back-to-back `wrt` immediately after `done`: a new transaction starts. `SS_n` is high for at least 1 clk between transactions.
- `shft` and `full` never coincide, because the divider decodes distinct counts. No priority rule is needed.

Optional Feature:
- Macro `SPI_XFER_CNT_EN`.
- Defined:
  - adds output port `xfer_cnt[15:0]`, reset 0;
  - increments on the same edge `done` rises;
  - wraps 0xFFFF to 0x0000;
  - an aborted transfer (reset) is not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then `cmd`=16'hA5C3 and `wrt` pulse with `MISO` tied to `MOSI` through a model slave that samples on SCLK rise and launches on fall:
  - exactly 16 SCLK rises;
  - `SS_n`=0 in cycles 1..520;
  - `done`=1 at cycle 521;
  - `rd_data`=16'hA5C3.
- Slave returns 16'h3C5A while master sends 16'hFFFF: `rd_data`=16'h3C5A; slave-captured word = 16'hFFFF.
- Second `wrt` in cycle 100 of a transfer, with a different `cmd`: ignored; `done` still at 521; `rd_data` matches the first transfer only.
- Assert `rst` in cycle 300:
  - `SS_n`=1, `done`=0, `ld_SCLK`=1 immediately (async);
  - after release, a fresh `wrt` completes normally at 521.
- `wrt` held high continuously for 3 transfers:
  - new transaction starts 1 clk after each `done`;
  - `SS_n` gap exactly 1 clk;
  - `done` low during each transfer.
- With `SPI_XFER_CNT_EN`: 3 completed transfers give `xfer_cnt`=3. Force the counter to 0xFFFF, complete one more transfer: `xfer_cnt`=0.
